hazard_ctrl: RTL

Pipeline hazard and flush controller for the in-order RV32I core. It sits beside the decode and execute stages. It keeps a per-register scoreboard of in-flight destination writes and stalls decode on read-after-write hazards or data-memory wait. When execute reports a taken branch or jump, it drives the execute stage's `halt` and `taken_branch` inputs.

---
 rtl/hazard_ctrl_pkg.sv | 49 ++++
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl_reg_scoreboard.sv | 78 +++++++
 rtl/hazard_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared definitions for the RV32I hazard/flush controller.
//                Holds the base opcodes, the controller state encoding and
//                the decode predicates that say which register fields an
//                opcode reads or writes.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

  localparam int XLEN        = 32;
  localparam int NUM_REGS    = 32;
  localparam int FLUSH_CNT_W = 3;   // holds FLUSH_CYCLES values 1..7

  // RV32I base opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic logic writes_rd(input logic [6:0] opc);
    return (opc == OPC_OP)  || (opc == OPC_OP_IMM) || (opc == OPC_LUI) ||
           (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR) ||
           (opc == OPC_LOAD);
  endfunction

  function automatic logic reads_rs1(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_BRANCH) ||
           (opc == OPC_JALR) || (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_BRANCH) || (opc == OPC_STORE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Pipeline-side bundle of the hazard controller.
//                master : pipeline (drives decode/execute/writeback info)
//                slave  : hazard_ctrl (drives halt/taken_branch/issue/perf)
//  Ports       : id_instr, id_valid, branch_en, mem_busy, wb_valid, wb_rd,
//                halt, taken_branch, issue, stall_cnt, flush_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [XLEN-1:0] id_instr;
  logic            id_valid;
  logic            branch_en;
  logic            mem_busy;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            halt;
  logic            taken_branch;
  logic            issue;
  logic [31:0]     stall_cnt;
  logic [31:0]     flush_cnt;

  modport master (
    output id_instr, id_valid, branch_en, mem_busy, wb_valid, wb_rd,
    input  halt, taken_branch, issue, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_instr, id_valid, branch_en, mem_busy, wb_valid, wb_rd,
    output halt, taken_branch, issue, stall_cnt, flush_cnt
  );

endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Per-register pending-write counters for x1..x31.
//                One increment port (issue) and one decrement port (retire);
//                lookup of "busy" (count != 0) for two sources and "full"
//                (count at maximum) for the destination. x0 reads as idle.
//  Ports       : clk, rst (async, active-low), inc_en/inc_idx,
//                dec_en/dec_idx, rs1_idx/rs2_idx/rd_idx,
//                rs1_busy, rs2_busy, rd_full
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_en,
  input  logic [4:0] inc_idx,
  input  logic       dec_en,
  input  logic [4:0] dec_idx,
  input  logic [4:0] rs1_idx,
  input  logic [4:0] rs2_idx,
  input  logic [4:0] rd_idx,
  output logic       rs1_busy,
  output logic       rs2_busy,
  output logic       rd_full
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REGS-1:0] busy_vec;
  logic [NUM_REGS-1:0] full_vec;

  // x0 is never tracked
  assign busy_vec[0] = 1'b0;
  assign full_vec[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             inc_hit;
    logic             dec_hit;

    assign inc_hit = inc_en && (inc_idx == 5'(i));
    assign dec_hit = dec_en && (dec_idx == 5'(i));

    // Simultaneous issue and retire cancel; retire of an idle register is
    // dropped. Increment never overflows because a full rd blocks issue.
    always_comb begin
      cnt_d = cnt_q;
      if (inc_hit && !dec_hit) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (dec_hit && !inc_hit && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign busy_vec[i] = (cnt_q != '0);
    assign full_vec[i] = (cnt_q == CNT_MAX);
  end

  assign rs1_busy = busy_vec[rs1_idx];
  assign rs2_busy = busy_vec[rs2_idx];
  assign rd_full  = full_vec[rd_idx];

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard and flush controller for the in-order RV32I core.
//                Stalls decode on RAW hazards (via reg_scoreboard) or on
//                data-memory wait, and squashes execute for FLUSH_CYCLES
//                cycles after a taken branch/jump.
//  Ports       : clk, rst (async, active-low), bus (hazard_ctrl_if.slave)
//  Config      : HAZARD_CTRL_PERF_EN - enables stall_cnt / flush_cnt
//                counters; otherwise both outputs are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 2
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  logic [6:0] opcode;
  logic [4:0] rd_idx;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;

  assign opcode  = bus.id_instr[6:0];
  assign rd_idx  = bus.id_instr[11:7];
  assign rs1_idx = bus.id_instr[19:15];
  assign rs2_idx = bus.id_instr[24:20];

  // funct fields play no part in hazard detection
  logic unused_bits;

  logic rd_tracked;
  logic rs1_used;
  logic rs2_used;
  assign rd_tracked = writes_rd(opcode) && (rd_idx != 5'd0);
  assign rs1_used   = reads_rs1(opcode);
  assign rs2_used   = reads_rs2(opcode);

  logic rs1_busy;
  logic rs2_busy;
  logic rd_full;
  logic hazard;

  state_e                 state_q, state_d;
  logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
  logic                   busy_lat_q, busy_lat_d;
  logic                   flush_entry;

  logic run;
  logic halt;
  logic issue;

  assign run    = (state_q == ST_RUN);
  assign hazard = (rs1_used && rs1_busy) || (rs2_used && rs2_busy) ||
                  (rd_tracked && rd_full);

  // Gated with rst so nothing issues or stalls while reset is held.
  assign issue = rst && run && bus.id_valid && !hazard &&
                 !bus.branch_en && !bus.mem_busy;
  assign halt  = rst && ((state_q == ST_HOLD) ||
                         (run && bus.id_valid && hazard));

  assign bus.issue        = issue;
  assign bus.halt         = halt;
  assign bus.taken_branch = (state_q == ST_FLUSH);

  reg_scoreboard #(
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (issue && rd_tracked),
    .inc_idx  (rd_idx),
    .dec_en   (bus.wb_valid && (bus.wb_rd != 5'd0)),
    .dec_idx  (bus.wb_rd),
    .rs1_idx  (rs1_idx),
    .rs2_idx  (rs2_idx),
    .rd_idx   (rd_idx),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_full  (rd_full)
  );

  // busy_lat remembers a mem_busy seen while flushing so the flush exits
  // into HOLD even if the memory wait began mid-flush.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    busy_lat_d  = busy_lat_q;
    flush_entry = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.branch_en) begin
          state_d     = ST_FLUSH;
          fcnt_d      = FLUSH_LOAD;
          busy_lat_d  = bus.mem_busy;
          flush_entry = 1'b1;
        end else if (bus.mem_busy) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!bus.mem_busy) begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (bus.branch_en) begin
          fcnt_d      = FLUSH_LOAD;
          busy_lat_d  = busy_lat_q || bus.mem_busy;
          flush_entry = 1'b1;
        end else if (fcnt_q <= FLUSH_CNT_W'(1)) begin
          state_d    = (busy_lat_q || bus.mem_busy) ? ST_HOLD : ST_RUN;
          fcnt_d     = '0;
          busy_lat_d = 1'b0;
        end else begin
          fcnt_d     = fcnt_q - FLUSH_CNT_W'(1);
          busy_lat_d = busy_lat_q || bus.mem_busy;
        end
      end
      default: begin
        state_d    = ST_RUN;
        fcnt_d     = '0;
        busy_lat_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      fcnt_q     <= '0;
      busy_lat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      busy_lat_q <= busy_lat_d;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + (halt ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q + (flush_entry ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign unused_bits   = ^{bus.id_instr[31:25], bus.id_instr[14:12]};
`else
  assign bus.stall_cnt = 32'd0;
  assign bus.flush_cnt = 32'd0;
  assign unused_bits   = ^{bus.id_instr[31:25], bus.id_instr[14:12],
                           flush_entry};
`endif

endmodule
`default_nettype wire
